// File: rtl/mux_pkg.sv
// Shared definitions for the streaming channel multiplexer.
//   MODE_MANUAL / MODE_RR : values of the top-level `mode` input
//   oh_index()            : position of the set bit in a one-hot vector
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Callers zero-extend their vector to 32 bits, so designs are limited to
  // 32 channels. A zero vector returns 0.
  function automatic int unsigned oh_index(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own priority pointer.
//   req         : per-channel request
//   advance     : a granted beat was taken; move the pointer
//   advance_idx : channel that was taken (becomes lowest priority)
//   grant       : one-hot or zero, search starts at ptr+1 and wraps
// The pointer resets to CHANNELS-1 so channel 0 is searched first.
module rr_arbiter #(
  parameter int CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         req,
  input  logic                        advance,
  input  logic [$clog2(CHANNELS)-1:0] advance_idx,
  output logic [CHANNELS-1:0]         grant
);

  localparam int PW = $clog2(CHANNELS);

  logic [PW-1:0] ptr;

  // Modulo walk rather than a power-of-two wrap so odd channel counts work.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(ptr) + i) % CHANNELS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= PW'(CHANNELS - 1);
    else if (advance) ptr <= advance_idx;
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
//   in_data/in_valid/in_ready : producer streams, channel k at [k*WIDTH +: WIDTH]
//   mode                      : MODE_MANUAL uses sel, MODE_RR arbitrates fairly
//   sel                       : manual channel select (out-of-range never grants)
//   out_data/out_chan         : registered beat and the channel it came from
//   out_valid/out_ready       : consumer handshake
// One cycle of latency, one beat per cycle when the consumer keeps up.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]            rr_grant, man_grant, grant;
  logic                           load_en, xfer, advance;
  logic [SEL_W-1:0]               xfer_idx;

  assign ch_data = in_data;

  // Register can take a beat when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  always_comb begin
    man_grant = '0;
    if (int'(sel) < CHANNELS && in_valid[sel])
      man_grant[sel] = 1'b1;
  end

  assign grant = (mode == MODE_RR) ? rr_grant : man_grant;

  // Gate with rst_n so no producer sees a handshake while reset is held.
  assign in_ready = rst_n ? (grant & {CHANNELS{load_en}}) : '0;

  // Grants only go to valid channels, so any ready bit is a transfer.
  assign xfer     = |in_ready;
  assign xfer_idx = SEL_W'(oh_index(32'(in_ready)));
  assign advance  = xfer && (mode == MODE_RR);

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (advance),
    .advance_idx (xfer_idx),
    .grant       (rr_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[xfer_idx];
      out_chan  <= xfer_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_stream_rr.sv
module tb_mux_stream_rr;

  localparam int WIDTH = 4;
  localparam int CHANNELS = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [CHANNELS*WIDTH-1:0] in_data = 16'hD9F3;
  logic [CHANNELS-1:0]       in_valid = '0;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode = 1'b0;
  logic [1:0]                sel = '0;
  logic [WIDTH-1:0]          out_data;
  logic [1:0]                out_chan;
  logic                      out_valid;
  logic                      out_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  logic [3:0] ch_val [4] = '{4'h3, 4'hF, 4'h9, 4'hD};

  mux_stream_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 4'b1111;
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_chan !== 2'd0) begin
      fails++;
      $display("FAIL reset_out: valid=%b data=%h chan=%0d want 0 0 0", out_valid, out_data, out_chan);
    end
    tests++;
    if (in_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    in_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual;
    mode = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      tests++;
      if (in_ready !== 4'(1 << s)) begin
        fails++;
        $display("FAIL manual_ready[%0d]: got %b want %b", s, in_ready, 4'(1 << s));
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== ch_val[s] || out_chan !== 2'(s)) begin
        fails++;
        $display("FAIL manual_out[%0d]: valid=%b data=%h chan=%0d want 1 %h %0d",
                 s, out_valid, out_data, out_chan, ch_val[s], s);
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_rr_all;
    do_reset();
    mode = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== 2'(i % 4) || out_data !== ch_val[i % 4]) begin
        fails++;
        $display("FAIL rr_all[%0d]: valid=%b chan=%0d data=%h want 1 %0d %h",
                 i, out_valid, out_chan, out_data, i % 4, ch_val[i % 4]);
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_rr_sparse;
    logic [1:0] exp_chan [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset();
    mode = 1'b1;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (in_ready !== 4'(1 << exp_chan[i])) begin
        fails++;
        $display("FAIL rr_sparse_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << exp_chan[i]));
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== exp_chan[i] || out_data !== ch_val[exp_chan[i]]) begin
        fails++;
        $display("FAIL rr_sparse[%0d]: valid=%b chan=%0d data=%h want 1 %0d %h",
                 i, out_valid, out_chan, out_data, exp_chan[i], ch_val[exp_chan[i]]);
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_stall;
    do_reset();
    mode = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin
        fails++;
        $display("FAIL stall_ready[%0d]: got %b want 0000", i, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 4'hF) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b chan=%0d data=%h want 1 1 f",
                 i, out_valid, out_chan, out_data);
      end
    end
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== 2'(i) || out_data !== ch_val[i]) begin
        fails++;
        $display("FAIL stall_resume[%0d]: valid=%b chan=%0d data=%h want 1 %0d %h",
                 i, out_valid, out_chan, out_data, i, ch_val[i]);
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_manual_none;
    do_reset();
    mode = 1'b0;
    sel = 2'd0;
    in_valid = 4'b1111;
    out_ready = 1'b0;
    tick();
    sel = 2'd2;
    in_valid = 4'b1011;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin
      fails++;
      $display("FAIL none_ready_stalled: got %b want 0000", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 4'h3) begin
      fails++;
      $display("FAIL none_hold: valid=%b chan=%0d data=%h want 1 0 3", out_valid, out_chan, out_data);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin
      fails++;
      $display("FAIL none_ready_drain: got %b want 0000", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 4'h3) begin
      fails++;
      $display("FAIL none_drain: valid=%b data=%h want 0 3", out_valid, out_data);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    mode = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 4'b0000) begin
      fails++;
      $display("FAIL async_reset: valid=%b data=%h ready=%b want 0 0 0000", out_valid, out_data, in_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== 2'(i) || out_data !== ch_val[i]) begin
        fails++;
        $display("FAIL async_restart[%0d]: valid=%b chan=%0d data=%h want 1 %0d %h",
                 i, out_valid, out_chan, out_data, i, ch_val[i]);
      end
    end
    in_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_manual();
    test_rr_all();
    test_rr_sparse();
    test_stall();
    test_manual_none();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
